// File: rtl/mux_scan_ctrl_if.sv
// Signal bundle between the scan controller and its host / downstream 4:1 mux.
// The controller uses the slave modport; the host side uses master.
interface mux_scan_ctrl_if;
    logic       start;
    logic       continuous;
    logic [3:0] ch_mask;
    logic       mux_out;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] sample;
    logic [3:0] sample_vld;
    logic       done;

    modport master (
        output start, continuous, ch_mask, mux_out,
        input  sel, busy, sample, sample_vld, done
    );

    modport slave (
        input  start, continuous, ch_mask, mux_out,
        output sel, busy, sample, sample_vld, done
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps a 4:1 mux through the enabled channels, waits DWELL cycles on each,
// samples the mux output and collects the bits into a parallel result word.
module mux_scan_ctrl #(
    parameter int unsigned DWELL = 2,
    parameter int unsigned CW    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    mask_q, mask_n;
    logic [3:0]    sample_q, sample_n;
    logic [3:0]    vld_q, vld_n;
    logic [1:0]    sel_q, sel_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic [3:0]    above;

    function automatic logic [1:0] low_idx(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mask_q   <= '0;
            sample_q <= '0;
            vld_q    <= '0;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            mask_q   <= mask_n;
            sample_q <= sample_n;
            vld_q    <= vld_n;
            sel_q    <= sel_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        mask_n   = mask_q;
        sample_n = sample_q;
        vld_n    = vld_q;
        sel_n    = sel_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
        // Enabled channels strictly above the current select
        above    = mask_q & (4'b1110 << sel_q);

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.ch_mask != '0) begin
                        mask_n  = bus.ch_mask;
                        vld_n   = '0;
                        sel_n   = low_idx(bus.ch_mask);
                        cnt_n   = RELOAD;
                        busy_n  = 1'b1;
                        state_n = SETTLE;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (cnt == '0) state_n = SAMPLE;
                else           cnt_n   = cnt - CW'(1);
            end
            SAMPLE: begin
                sample_n[sel_q] = bus.mux_out;
                vld_n[sel_q]    = 1'b1;
                if (above != '0) begin
                    sel_n   = low_idx(above);
                    cnt_n   = RELOAD;
                    state_n = SETTLE;
                end else begin
                    done_n = 1'b1;
                    // Continuous restart re-latches the live mask with no idle gap
                    if (bus.continuous && bus.ch_mask != '0) begin
                        mask_n  = bus.ch_mask;
                        sel_n   = low_idx(bus.ch_mask);
                        cnt_n   = RELOAD;
                        state_n = SETTLE;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.sel        = sel_q;
    assign bus.busy       = busy_q;
    assign bus.sample     = sample_q;
    assign bus.sample_vld = vld_q;
    assign bus.done       = done_q;

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencing controller that sits directly upstream of the 4:1 mux. It drives the mux select lines, waits a programmable settle time on each enabled channel, samples the mux output, and assembles the four sampled bits into a parallel result word. It supports single-shot and continuous scanning and a per-channel enable mask. A one-cycle `done` pulse marks the end of each scan.

## Interface
- `DWELL`, default 2: settle cycles per channel before sampling; legal range 1..255.
- `CW`, default 8: width of the internal dwell counter; must satisfy DWELL ≤ 2^CW − 1.

- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: single-cycle request to begin a scan; ignored while `busy`=1.
- `continuous` in 1: when high at the end of a scan, immediately start the next scan.
- `ch_mask` in 4: channel enables; bit i enables channel i.
- `mux_out` in 1: output of the downstream 4:1 mux.
- `sel` out 2: select lines driven to the mux.
- `busy` out 1: high from the cycle after an accepted `start` until the scan ends.
- `sample` out 4: bit i holds the last value sampled on channel i.
- `sample_vld` out 4: bit i is set once channel i has been sampled in the current scan sequence.
- `done` out 1: one-cycle pulse at the end of each scan.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE.
- **IDLE**
  - On `start`=1 with `ch_mask`≠0: latch `ch_mask` into `mask_q`, clear `sample_vld`, set `sel` = index of the lowest set bit, load dwell count = DWELL−1, set `busy`=1, go to SETTLE.
  - On `start`=1 with `ch_mask`=0: pulse `done` for one cycle, stay in IDLE, leave `busy`=0 and `sample`/`sample_vld` unchanged.
- **SETTLE**: `sel` held stable. Decrement the count each cycle; when the count is 0, go to SAMPLE.
- **SAMPLE**: at the clock edge, `sample[sel]` ← `mux_out` and `sample_vld[sel]` ← 1. Then:
  - If `mask_q` has a set bit above `sel`: `sel` ← the next higher enabled index, reload the count, go to SETTLE.
  - Otherwise the scan is complete and `done` ← 1 for one cycle.
    - If `continuous`=1 and the live `ch_mask`≠0: re-latch `mask_q` ← `ch_mask`, `sel` ← its lowest set index, go to SETTLE with `busy` kept at 1. `sample_vld` is not cleared.
    - Otherwise: go to IDLE, `busy` ← 0, `sel` keeps its last value.
- Channels disabled in `mask_q` are never selected. Their `sample` and `sample_vld` bits are not modified.
- `ch_mask` changes during a scan have no effect until the next latch point (scan start or continuous restart).
- `start` is ignored in SETTLE and SAMPLE.
- Reset values (next edge with `rst_n`=0, from any state, including mid-scan): state IDLE, `sel`=0, `busy`=0, `done`=0, `sample`=0, `sample_vld`=0, count=0.

## Timing
- Let E0 be the edge at which `start` is accepted. Outputs change after each edge listed.
  - E0: `busy`=1, `sel` = first channel.
  - E0+DWELL: state is SAMPLE.
  - E0+DWELL+1: first channel's `sample` bit updated; `sel` = next channel.
- Each enabled channel costs DWELL+1 cycles. For N enabled channels, the last sample, `done`=1, and `busy`=0 (single-shot) all take effect at edge E0+N·(DWELL+1).
- `mux_out` is taken at the SAMPLE edge, i.e. DWELL+1 cycles after `sel` changed. The mux is combinational, so no further alignment is needed.
- In continuous mode there is zero gap between scans: `sel` moves to the new first channel at the same edge that `done` rises.
- The earliest next `start` after a single-shot scan is accepted at edge E0+N·(DWELL+1)+1.

## Test plan
- **Single-shot, full mask.** Reset, DWELL=2, `ch_mask`=1111, mux inputs 1010 (channel i = bit i), pulse `start` → `sel` steps 0,1,2,3 for 3 cycles each. `done` and `busy`=0 appear 12 cycles after the start edge. `sample`=1010, `sample_vld`=1111.
- **Sparse mask.** `ch_mask`=1001, inputs 1111 → `sel` only takes values 0 and 3. `done` after 6 cycles, `sample`=1001, `sample_vld`=1001.
- **Zero mask.** `ch_mask`=0000 with `start` → `done` high for exactly 1 cycle, `busy` stays 0, `sel`/`sample` unchanged.
- **Continuous mode.** `continuous`=1, `ch_mask`=0011; change the inputs between scans → `done` pulses every 6 cycles, `busy` stays 1, `sample` tracks the new inputs. Deassert `continuous` → the current scan completes, then `busy`=0.
- **Start and mask while busy.** Pulse `start` and change `ch_mask` to 0100 mid-scan of 1111 → no restart, all 4 channels still scanned, and the new mask is used only on the next scan.
- **Reset mid-scan.** Assert `rst_n`=0 during SETTLE of channel 2 → next edge: `sel`=0, `busy`=0, `done`=0, `sample`=0000, `sample_vld`=0000. A subsequent `start` begins a clean scan.
